sdram_pattern_tester: RTL

//  Parametrised hardware memory tester: an Avalon-MM master that fills an SDRAM region with a selectable

---
 rtl/sdram_pattern_tester_if.sv | 40 ++++
 rtl/sdram_pattern_tester.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pattern_tester_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pattern_tester_if
//  Description : Avalon-MM bus bundle between the pattern tester (master)
//                and an SDRAM controller slave port.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    avm_address        master->slave  byte address
//    avm_read/write     master->slave  command strobes
//    avm_writedata      master->slave  write data
//    avm_byteenable     master->slave  byte lanes
//    avm_readdata       slave->master  read data
//    avm_readdatavalid  slave->master  read data qualifier, in order
//    avm_waitrequest    slave->master  stall, command held while high
// ============================================================================
interface sdram_pattern_tester_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;
    logic                avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/sdram_pattern_tester.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pattern_tester
//  Description : Avalon-MM memory tester. Fills a region with a selectable
//                pattern, reads it back with pipelined reads and compares
//                in order against an independent expected-data generator.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_clk, reset_reset_n      clock, synchronous active-low reset
//    start, abort                control pulses
//    mode, loop_en, region_words run configuration, latched on start
//    avm                         Avalon-MM master bus
//    busy, done, pass            status (done sticky until next start)
//    err_count, first_err_addr   mismatch statistics
//    pass_count                  completed passes, wraps
// ============================================================================
module sdram_pattern_tester #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 25,
    parameter int                MAX_PEND  = 8,
    parameter logic [31:0]       LFSR_SEED = 32'hACE1
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic                   loop_en,
    input  logic [CNT_W-1:0]       region_words,
    sdram_pattern_tester_if.master avm,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            err_count,
    output logic [ADDR_W-1:0]      first_err_addr,
    output logic [15:0]            pass_count
);
    localparam int          c_bytes     = DATA_W / 8;
    localparam int          c_pend_w    = $clog2(MAX_PEND) + 1;
    localparam logic [31:0] c_lfsr_mask = 32'h8020_0003;   // taps 32,22,2,1

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? c_lfsr_mask : 32'h0);
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [CNT_W-1:0] i,
                                                  input logic [31:0] l, input logic p);
        logic [DATA_W-1:0] v;
        case (m)
            2'd0:    v = DATA_W'(i);
            2'd1:    v = DATA_W'(1) << (i % CNT_W'(DATA_W));
            2'd2:    v = DATA_W'(l);
            default: v = {(DATA_W/2){2'b10}} ^ {DATA_W{i[0] ^ p}};
        endcase
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CNT_W-1:0] i);
        return BASE_ADDR + ADDR_W'(i) * ADDR_W'(c_bytes);
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      idx_q, idx_d;             // next word to issue
    logic [CNT_W-1:0]      last_idx_q, last_idx_d;
    logic [1:0]            cfg_mode_q, cfg_mode_d;
    logic                  cfg_loop_q, cfg_loop_d;
    logic                  abort_seen_q, abort_seen_d;
    logic                  cut_q, cut_d;             // issue stopped early by abort
    logic [c_pend_w-1:0]   pending_q, pending_d;
    logic [31:0]           wr_lfsr_q, wr_lfsr_d;
    logic [31:0]           exp_lfsr_q, exp_lfsr_d;
    logic [CNT_W-1:0]      exp_idx_q, exp_idx_d;     // word index of next readdata
    logic [15:0]           err_count_q, err_count_d;
    logic [ADDR_W-1:0]     first_err_q, first_err_d;
    logic [15:0]           pass_count_q, pass_count_d;
    logic                  pass_q, pass_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

    logic                  w_wr_acc, w_rd_acc, w_rdv, w_stop, w_busy;
    logic [DATA_W-1:0]     w_exp_data;
    logic                  w_launch, w_launch_p;
    logic [1:0]            w_launch_mode;
    logic [CNT_W-1:0]      w_idx_inc;

    assign w_wr_acc   = wr_q & ~avm.avm_waitrequest;
    assign w_rd_acc   = rd_q & ~avm.avm_waitrequest;
    // Data with nothing outstanding (e.g. in flight across a reset) is dropped.
    assign w_rdv      = avm.avm_readdatavalid && (pending_q != '0);
    assign w_stop     = abort_seen_q | abort;
    assign w_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign w_exp_data = pattern(cfg_mode_q, exp_idx_q, exp_lfsr_q, pass_count_q[0]);
    assign w_idx_inc  = idx_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        last_idx_d    = last_idx_q;
        cfg_mode_d    = cfg_mode_q;
        cfg_loop_d    = cfg_loop_q;
        abort_seen_d  = abort_seen_q | (abort & w_busy);
        cut_d         = cut_q;
        pending_d     = pending_q + c_pend_w'(w_rd_acc) - c_pend_w'(w_rdv);
        wr_lfsr_d     = wr_lfsr_q;
        exp_lfsr_d    = exp_lfsr_q;
        exp_idx_d     = exp_idx_q;
        err_count_d   = err_count_q;
        first_err_d   = first_err_q;
        pass_count_d  = pass_count_q;
        pass_d        = pass_q;
        addr_d        = addr_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        wdata_d       = wdata_q;
        w_launch      = 1'b0;
        w_launch_p    = 1'b0;
        w_launch_mode = cfg_mode_q;

        if (w_rdv) begin
            if (avm.avm_readdata != w_exp_data) begin
                if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                if (err_count_q == 16'd0)    first_err_d = addr_of(exp_idx_q);
            end
            exp_idx_d  = exp_idx_q + CNT_W'(1);
            exp_lfsr_d = lfsr_next(exp_lfsr_q);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cfg_mode_d    = mode;
                    cfg_loop_d    = loop_en;
                    last_idx_d    = (region_words == '0) ? '0 : region_words - CNT_W'(1);
                    abort_seen_d  = 1'b0;
                    cut_d         = 1'b0;
                    err_count_d   = '0;
                    first_err_d   = '0;
                    pass_count_d  = '0;
                    pass_d        = 1'b0;
                    w_launch      = 1'b1;
                    w_launch_mode = mode;
                end
            end
            S_WRITE: begin
                // A stalled command stays on the bus until it is accepted.
                if (!wr_q || w_wr_acc) begin
                    if (w_stop) begin
                        wr_d    = 1'b0;
                        cut_d   = 1'b1;
                        state_d = S_DRAIN;
                    end else if (w_wr_acc && idx_q == last_idx_q) begin
                        wr_d       = 1'b0;
                        idx_d      = '0;
                        exp_idx_d  = '0;
                        exp_lfsr_d = LFSR_SEED;
                        state_d    = S_READ;
                    end else if (w_wr_acc) begin
                        idx_d     = w_idx_inc;
                        wr_lfsr_d = lfsr_next(wr_lfsr_q);
                        addr_d    = addr_of(w_idx_inc);
                        wdata_d   = pattern(cfg_mode_q, w_idx_inc, lfsr_next(wr_lfsr_q), pass_count_q[0]);
                    end
                end
            end
            S_READ: begin
                if (!rd_q || w_rd_acc) begin
                    if (w_stop) begin
                        rd_d    = 1'b0;
                        cut_d   = 1'b1;
                        state_d = S_DRAIN;
                    end else if (w_rd_acc && idx_q == last_idx_q) begin
                        rd_d    = 1'b0;
                        state_d = S_DRAIN;
                    end else begin
                        if (w_rd_acc) idx_d = w_idx_inc;
                        // Gate on the post-edge count so an accepted read never overflows.
                        rd_d   = (pending_d < c_pend_w'(MAX_PEND));
                        addr_d = addr_of(w_rd_acc ? w_idx_inc : idx_q);
                    end
                end
            end
            S_DRAIN: begin
                if (pending_q == '0) begin
                    if (cut_q) begin
                        pass_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                pass_count_d = pass_count_q + 16'd1;
                if (cfg_loop_q && !w_stop) begin
                    w_launch   = 1'b1;
                    w_launch_p = pass_count_d[0];
                end else begin
                    pass_d  = (err_count_q == 16'd0) && !w_stop;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Begin a write phase with word 0 already on the bus.
        if (w_launch) begin
            state_d   = S_WRITE;
            idx_d     = '0;
            wr_lfsr_d = LFSR_SEED;
            wr_d      = 1'b1;
            addr_d    = addr_of('0);
            wdata_d   = pattern(w_launch_mode, '0, LFSR_SEED, w_launch_p);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            last_idx_q   <= '0;
            cfg_mode_q   <= '0;
            cfg_loop_q   <= 1'b0;
            abort_seen_q <= 1'b0;
            cut_q        <= 1'b0;
            pending_q    <= '0;
            wr_lfsr_q    <= '0;
            exp_lfsr_q   <= '0;
            exp_idx_q    <= '0;
            err_count_q  <= '0;
            first_err_q  <= '0;
            pass_count_q <= '0;
            pass_q       <= 1'b0;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_idx_q   <= last_idx_d;
            cfg_mode_q   <= cfg_mode_d;
            cfg_loop_q   <= cfg_loop_d;
            abort_seen_q <= abort_seen_d;
            cut_q        <= cut_d;
            pending_q    <= pending_d;
            wr_lfsr_q    <= wr_lfsr_d;
            exp_lfsr_q   <= exp_lfsr_d;
            exp_idx_q    <= exp_idx_d;
            err_count_q  <= err_count_d;
            first_err_q  <= first_err_d;
            pass_count_q <= pass_count_d;
            pass_q       <= pass_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign avm.avm_address    = addr_q;
    assign avm.avm_read       = rd_q;
    assign avm.avm_write      = wr_q;
    assign avm.avm_writedata  = wdata_q;
    // All lanes enabled whenever a command is presented; idle bus reads as zero.
    assign avm.avm_byteenable = {c_bytes{wr_q | rd_q}};

    assign busy           = w_busy;
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;
    assign pass_count     = pass_count_q;
endmodule
`default_nettype wire
